// File: rtl/stream_muxn.sv
// N-channel valid/ready stream mux with one registered output stage; optional round-robin via STREAM_MUXN_RR_EN.
// Latency: 1 cycle from input handshake to out_*; 1 word/cycle sustained while out_ready is high.
// Backpressure: in_ready of the chosen channel follows (!out_valid || out_ready); all others see 0.
module stream_muxn #(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic [SELW-1:0]      sel,
   input  logic                 rr_mode,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      grant_idx
);

   // N widened by one bit so the range test also works when N is a power of two
   localparam logic [SELW:0] NLIM = (SELW+1)'(N);

   logic                 load_ok;
   logic [SELW-1:0]      chosen;
   logic                 chosen_vld;
   logic                 take;
   logic [WIDTH-1:0]     ch_data [N];

   assign load_ok = !out_valid || out_ready;

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

`ifdef STREAM_MUXN_RR_EN
   logic [SELW-1:0] last;
   logic [SELW-1:0] rr_idx;
   logic            rr_hit;
   logic [SELW-1:0] cand;

   // Scan last+1 .. last+N (mod N) and pick the first valid channel
   always_comb begin
      rr_idx = '0;
      rr_hit = 1'b0;
      cand   = '0;
      for (int k = 1; k <= N; k++) begin
         cand = SELW'((int'(last) + k) % N);
         if (!rr_hit && in_valid[cand]) begin
            rr_hit = 1'b1;
            rr_idx = cand;
         end
      end
   end

   // Pointer only advances on round-robin grants; reset gives channel 0 first priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= SELW'(N-1);
      end else if (take && rr_mode) begin
         last <= chosen;
      end
   end

   // Channel choice: round-robin result when enabled, otherwise the explicit select
   always_comb begin
      chosen     = sel;
      chosen_vld = ({1'b0, sel} < NLIM);
      if (rr_mode) begin
         chosen     = rr_idx;
         chosen_vld = rr_hit;
      end
   end
`else
   logic unused_rr_mode;
   assign unused_rr_mode = rr_mode;

   // Channel choice: explicit select only; an out-of-range select chooses nothing
   always_comb begin
      chosen     = sel;
      chosen_vld = ({1'b0, sel} < NLIM);
   end
`endif

   // Only the chosen channel may see ready, and only when the output stage can load
   always_comb begin
      in_ready = '0;
      if (chosen_vld && load_ok) begin
         in_ready[chosen] = 1'b1;
      end
   end

   assign take = chosen_vld && load_ok && in_valid[chosen];

   // Output register: load on transfer, drain when consumer takes the word, hold under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         grant_idx <= '0;
      end else if (take) begin
         out_valid <= 1'b1;
         out_data  <= ch_data[chosen];
         grant_idx <= chosen;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
